next_pc: RTL and testbench
==========================

NEXT_PC -- requirements
Module: next_pc

Interface
REQ-001 SHALL have parameter D, default 12, meaning the width in bits of every address and program-counter signal.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: synchronous load of start_address into the PC.
REQ-005 SHALL have port branch, input, 1 bit: the current instruction is a branch.
REQ-006 SHALL have port taken, input, 1 bit: the branch condition is true.
REQ-007 SHALL have port start_address, input, D bits: absolute address loaded on start.
REQ-008 SHALL have port target, input, D bits: absolute branch destination.
REQ-009 SHALL have port prog_ctr_out, output, D bits: the current registered PC.
REQ-010 SHALL have port prog_ctr_in, output, D bits: the combinational next PC presented to the register.

Function
REQ-011 SHALL compute prog_ctr_in combinationally with priority: start=1 gives start_address; else branch=1 and taken=1 gives target; else prog_ctr_out+1.
REQ-012 SHALL treat target as an absolute address (no PC-relative add).
REQ-013 SHALL perform the increment modulo 2^D, so that (2^D)-1 wraps to 0 with no carry output.
REQ-014 SHALL load prog_ctr_in into prog_ctr_out on every rising clk edge while rst_n=1, giving a latency of one cycle from input change to prog_ctr_out.
REQ-015 SHALL ignore target when branch=1 and taken=0, and SHALL increment the PC.
REQ-016 SHALL ignore target when taken=1 and branch=0, and SHALL increment the PC.
REQ-017 SHALL give start precedence over a simultaneous branch=1, taken=1.
REQ-018 SHALL reload start_address on every edge while start is held high (PC holds at start_address).
REQ-019 SHALL keep a branch to the current PC (target = prog_ctr_out) at that value, which is a legal self-loop.
REQ-020 SHALL have no enable or stall input; the PC advances every cycle.

Reset
REQ-021 SHALL, while rst_n=0, force prog_ctr_out to 0 immediately, independent of clk.
REQ-022 SHALL, during reset, keep prog_ctr_in following REQ-011 using prog_ctr_out=0 (value 1 with all controls low).
REQ-023 SHALL resume loading on the first rising clk edge after rst_n rises; a reset mid-branch discards the pending target.

Structure
REQ-024 SHALL place the address width constant (default 12) in a shared package used by this block and the instruction memory.
REQ-025 SHALL implement the storage as one sub-module, pc_reg (D-bit register with async active-low reset), and keep the next-PC mux in next_pc.
REQ-026 SHALL contain no latches, and SHALL keep all outputs free of X after reset.

Verification
REQ-027 SHALL verify: rst_n pulsed low mid-cycle -> prog_ctr_out=0 immediately; release with controls low -> 1, 2, 3 on the next edges.
REQ-028 SHALL verify: start=1, start_address=0 for one edge, then start=0 for 3 edges -> 0, 1, 2, 3.
REQ-029 SHALL verify: PC=3, branch=1, taken=0, target=16 -> 4; then taken=1 -> 16; then target=2 -> 2.
REQ-030 SHALL verify: branch=0, taken=1, PC=2 -> 3, 4, 5 (no branch).
REQ-031 SHALL verify: start=1, start_address=128, branch=1, taken=1, target=16 -> 128; then start=0, branch=0 -> 129.
REQ-032 SHALL verify: start_address=4095 loaded, then increment -> 0 (wrap, D=12).

Source files
------------

// File: rtl/next_pc_pkg.sv
// Shared definitions for the program-counter path and instruction memory.
// Holds the common address width and the next-PC source encoding.
package next_pc_pkg;

  localparam int unsigned ADDR_W = 12;

  typedef enum logic [1:0] {
    SEL_INC    = 2'd0,
    SEL_START  = 2'd1,
    SEL_TARGET = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/next_pc_if.sv
// Bundle of the program-counter control inputs and PC outputs.
// The master drives start/branch controls; the slave returns the PC values.
interface next_pc_if
  import next_pc_pkg::*;
#(
  parameter int D = ADDR_W
);

  logic         start;
  logic         branch;
  logic         taken;
  logic [D-1:0] start_address;
  logic [D-1:0] target;
  logic [D-1:0] prog_ctr_out;
  logic [D-1:0] prog_ctr_in;

  modport master (
    output start, branch, taken, start_address, target,
    input  prog_ctr_out, prog_ctr_in
  );

  modport slave (
    input  start, branch, taken, start_address, target,
    output prog_ctr_out, prog_ctr_in
  );

endinterface

// File: rtl/next_pc_pc_reg.sv
// D-bit program-counter storage with asynchronous active-low clear.
module pc_reg
  import next_pc_pkg::*;
#(
  parameter int D = ADDR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [D-1:0] pc_d,
  output logic [D-1:0] pc_q
);

  // PC register: cleared immediately on reset, otherwise loads every edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/next_pc.sv
// Next-PC selection: start load, taken branch to an absolute target, or
// increment modulo 2^D; the chosen value is registered in pc_reg.
module next_pc
  import next_pc_pkg::*;
#(
  parameter int D = ADDR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         branch,
  input  logic         taken,
  input  logic [D-1:0] start_address,
  input  logic [D-1:0] target,
  output logic [D-1:0] prog_ctr_out,
  output logic [D-1:0] prog_ctr_in
);

  pc_sel_e      sel_s;
  logic [D-1:0] prog_ctr_d;
  logic [D-1:0] prog_ctr_q;
  logic [D-1:0] pc_inc_s;

  // Increment drops the carry so the top address wraps to zero
  assign pc_inc_s = prog_ctr_q + {{(D-1){1'b0}}, 1'b1};

  // Source priority: start beats a taken branch, which beats increment
  always_comb begin
    sel_s = SEL_INC;
    if (start) begin
      sel_s = SEL_START;
    end else if (branch && taken) begin
      sel_s = SEL_TARGET;
    end else begin
      sel_s = SEL_INC;
    end
  end

  // Next-PC mux
  always_comb begin
    prog_ctr_d = pc_inc_s;
    case (sel_s)
      SEL_START:  prog_ctr_d = start_address;
      SEL_TARGET: prog_ctr_d = target;
      SEL_INC:    prog_ctr_d = pc_inc_s;
      default:    prog_ctr_d = pc_inc_s;
    endcase
  end

  pc_reg #(.D(D)) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .pc_d  (prog_ctr_d),
    .pc_q  (prog_ctr_q)
  );

  assign prog_ctr_in  = prog_ctr_d;
  assign prog_ctr_out = prog_ctr_q;

endmodule

// File: tb/tb_next_pc.sv
// Self-checking bench for next_pc: vector table with an expected-PC queue,
// plus hand-written reset sequences.
module tb_next_pc;
  import next_pc_pkg::*;

  localparam int D = ADDR_W;
  localparam int NV = 17;

  typedef struct packed {
    logic         start;
    logic         branch;
    logic         taken;
    logic [D-1:0] start_address;
    logic [D-1:0] target;
    logic [D-1:0] exp_next;
  } vec_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  vec_t vecs [NV];
  logic [D-1:0] exp_q [$];
  logic [D-1:0] exp_v;

  next_pc_if #(.D(D)) bus ();

  next_pc #(.D(D)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (bus.start),
    .branch        (bus.branch),
    .taken         (bus.taken),
    .start_address (bus.start_address),
    .target        (bus.target),
    .prog_ctr_out  (bus.prog_ctr_out),
    .prog_ctr_in   (bus.prog_ctr_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [D-1:0] act, input logic [D-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic b, input logic t,
                       input logic [D-1:0] sa, input logic [D-1:0] tg);
    bus.start         = s;
    bus.branch        = b;
    bus.taken         = t;
    bus.start_address = sa;
    bus.target        = tg;
  endtask

  initial begin
    tests = 0;
    fails = 0;

    //           start  branch taken  start_addr  target     next PC
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 12'd0,    12'd0,   12'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 12'd0,    12'd0,   12'd1};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 12'd0,    12'd0,   12'd2};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 12'd0,    12'd0,   12'd3};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 12'd0,    12'd16,  12'd4};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 12'd0,    12'd16,  12'd16};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 12'd0,    12'd2,   12'd2};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 12'd0,    12'd16,  12'd3};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 12'd0,    12'd16,  12'd4};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 12'd0,    12'd16,  12'd5};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 12'd128,  12'd16,  12'd128};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 12'd128,  12'd16,  12'd128};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 12'd128,  12'd16,  12'd129};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 12'd0,    12'd129, 12'd129};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 12'd4095, 12'd0,   12'd4095};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 12'd0,    12'd0,   12'd0};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 12'd0,    12'd0,   12'd1};

    // Power-on reset: PC held at 0, next PC is 1 with controls low
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    #2;
    check("reset_out", bus.prog_ctr_out, 12'd0);
    check("reset_in", bus.prog_ctr_in, 12'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      check("post_reset_count", bus.prog_ctr_out, D'(k));
    end

    // Mid-cycle reset pulse clears PC without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_out", bus.prog_ctr_out, 12'd0);
    #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      check("after_pulse_count", bus.prog_ctr_out, D'(k));
    end

    // Vector table: next PC checked combinationally, then queued for the register
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].start, vecs[i].branch, vecs[i].taken,
            vecs[i].start_address, vecs[i].target);
      @(negedge clk);
      check($sformatf("vec%0d_in", i), bus.prog_ctr_in, vecs[i].exp_next);
      exp_q.push_back(vecs[i].exp_next);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL vec%0d_out: queue empty, got %0d", i, bus.prog_ctr_out);
      end else begin
        exp_v = exp_q.pop_front();
        check($sformatf("vec%0d_out", i), bus.prog_ctr_out, exp_v);
      end
    end

    // Reset during a taken branch: target visible on prog_ctr_in but discarded
    drive(1'b0, 1'b1, 1'b1, '0, 12'd16);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midbranch_reset_out", bus.prog_ctr_out, 12'd0);
    check("midbranch_reset_in", bus.prog_ctr_in, 12'd16);
    #1;
    drive(1'b0, 1'b0, 1'b0, '0, 12'd16);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midbranch_resume", bus.prog_ctr_out, 12'd1);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: got %0d left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
